// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
// Sequential packed-BCD to binary converter (reverse double-dabble).
// A packed-BCD operand is loaded into the upper half of a 2W-bit work
// register and shifted right one bit per clock. After every shift, each
// BCD digit of the upper half that reads >= 8 has 3 subtracted. After W
// shifts, the lower half holds the binary value.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   bcd_in is valid
//   in_ready   block can accept an operand (IDLE only)
//   bcd_in     packed BCD operand, digit 0 in [3:0]
//   out_valid  bin_out/err are valid (DONE only)
//   out_ready  consumer accepts the result
//   bin_out    binary value of the operand, forced to 0 when err is set
//   err        at least one operand digit was greater than 9
module bcd_to_bin_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bin_out,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  // The counter holds the number of shifts already done, so the step taken
  // while it reads W-1 is the W-th and last one.
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    hi_reg, hi_next;
  logic [W-1:0]    lo_reg, lo_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            err_reg, err_next;

  logic [W-1:0]      hi_shift;
  logic [W-1:0]      lo_shift;
  logic [W-1:0]      hi_fix;
  logic [DIGITS-1:0] digit_bad;

  // One right shift of the 2W-bit {hi, lo} work register.
  assign hi_shift = hi_reg >> 1;
  assign lo_shift = {hi_reg[0], lo_reg[W-1:1]};

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      // A digit reads >= 8 after the shift exactly when a weight-10 bit
      // moved down into its MSB, where it only carries weight 5.
      assign hi_fix[4*gi +: 4] = hi_shift[4*gi+3] ? (hi_shift[4*gi +: 4] - 4'd3)
                                                  : hi_shift[4*gi +: 4];
      // Digit > 9: 1010..1111, i.e. bit 3 set together with bit 2 or bit 1.
      assign digit_bad[gi] = bcd_in[4*gi+3] & (bcd_in[4*gi+2] | bcd_in[4*gi+1]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          hi_next    = bcd_in;
          lo_next    = '0;
          err_next   = |digit_bad;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Bad digits still run all W steps so latency never depends on data.
        hi_next  = hi_fix;
        lo_next  = lo_shift;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every output is decoded from registered state only, so there is no
  // combinational path from in_valid/out_ready to any output.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign bin_out   = (out_valid && !err_reg) ? lo_reg : '0;
  assign err       = out_valid & err_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq
// Self-checking bench for bcd_to_bin_seq: a DIGITS=4 instance and a
// DIGITS=2 instance share clock and reset. Expected results come from a
// behavioural decimal model and are queued when an operand is driven.
module tb_bcd_to_bin_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [15:0] bcd_in, bin_out;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, err2;
  logic [7:0]  bcd_in2, bin_out2;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [32:0] sb_q[$];
  time         accept_t;

  bcd_to_bin_seq #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out), .err(err)
  );

  bcd_to_bin_seq #(.DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .bcd_in(bcd_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .bin_out(bin_out2), .err(err2)
  );

  // Decimal reference: {err, binary}; binary forced to 0 on any digit > 9.
  function automatic logic [32:0] model(input int digits, input logic [31:0] bcd);
    logic [31:0] val;
    logic        bad;
    int          mult;
    val  = 32'd0;
    bad  = 1'b0;
    mult = 1;
    for (int i = 0; i < digits; i++) begin
      int d;
      d = int'(bcd[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      val  = val + 32'(d * mult);
      mult = mult * 10;
    end
    return bad ? {1'b1, 32'd0} : {1'b0, val};
  endfunction

  // Drive one operand into dut4 at the next rising edge.
  task automatic accept4(input logic [15:0] v, input bit track);
    @(negedge clk);
    in_valid = 1'b1;
    bcd_in   = v;
    if (track) sb_q.push_back(model(4, 32'(v)));
    @(posedge clk);
    accept_t = $time;
    #1 in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_done4(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic run4(input logic [15:0] v, output int lat, output logic [15:0] b,
                      output logic e, output logic rdy_after, output logic vld_after);
    accept4(v, 1'b1);
    wait_done4(lat);
    b = bin_out;
    e = err;
    if (lat >= 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    rdy_after = in_ready;
    vld_after = out_valid;
    $display("txn dut4 bcd=%h bin=%h err=%b lat=%0d", v, b, e, lat);
  endtask

  task automatic run2(input logic [7:0] v, output int lat, output logic [7:0] b,
                      output logic e);
    @(negedge clk);
    in_valid2 = 1'b1;
    bcd_in2   = v;
    sb_q.push_back(model(2, 32'(v)));
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid2) begin
        lat = i - 1;
        break;
      end
    end
    b = bin_out2;
    e = err2;
    if (lat >= 0) begin
      out_ready2 = 1'b1;
      @(posedge clk);
      #1 out_ready2 = 1'b0;
    end
    $display("txn dut2 bcd=%h bin=%h err=%b lat=%0d", v, b, e, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; bcd_in2 = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (bin_out !== 16'h0)    begin n_fail++; $display("FAIL reset_bin_out got %h want 0000", bin_out); end
    n_cmp++; if (err !== 1'b0)         begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (in_ready2 !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready2 got %b want 1", in_ready2); end
    n_cmp++; if (out_valid2 !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid2 got %b want 0", out_valid2); end
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_basic();
    int lat; logic [15:0] b; logic e, r, v; logic [32:0] ex;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready got %b want 1", in_ready); end
    run4(16'h1234, lat, b, e, r, v);
    ex = sb_q.pop_front();
    n_cmp++; if (lat !== 16)        begin n_fail++; $display("FAIL basic_latency got %0d want 16", lat); end
    n_cmp++; if (b !== ex[15:0])    begin n_fail++; $display("FAIL basic_bin got %h want %h", b, ex[15:0]); end
    n_cmp++; if (e !== ex[32])      begin n_fail++; $display("FAIL basic_err got %b want %b", e, ex[32]); end
    n_cmp++; if (r !== 1'b1)        begin n_fail++; $display("FAIL basic_ready_after got %b want 1", r); end
    n_cmp++; if (v !== 1'b0)        begin n_fail++; $display("FAIL basic_valid_after got %b want 0", v); end
  endtask

  task automatic test_boundary();
    logic [15:0] vals[4] = '{16'h0000, 16'h9999, 16'h0009, 16'h1000};
    int lat; logic [15:0] b; logic e, r, v; logic [32:0] ex;
    foreach (vals[k]) begin
      run4(vals[k], lat, b, e, r, v);
      ex = sb_q.pop_front();
      n_cmp++; if (lat !== 16)     begin n_fail++; $display("FAIL boundary_latency bcd=%h got %0d want 16", vals[k], lat); end
      n_cmp++; if (b !== ex[15:0]) begin n_fail++; $display("FAIL boundary_bin bcd=%h got %h want %h", vals[k], b, ex[15:0]); end
      n_cmp++; if (e !== ex[32])   begin n_fail++; $display("FAIL boundary_err bcd=%h got %b want %b", vals[k], e, ex[32]); end
    end
  endtask

  task automatic test_error();
    logic [15:0] vals[2] = '{16'h12A4, 16'h0042};
    int lat; logic [15:0] b; logic e, r, v; logic [32:0] ex;
    foreach (vals[k]) begin
      run4(vals[k], lat, b, e, r, v);
      ex = sb_q.pop_front();
      n_cmp++; if (lat !== 16)     begin n_fail++; $display("FAIL error_latency bcd=%h got %0d want 16", vals[k], lat); end
      n_cmp++; if (b !== ex[15:0]) begin n_fail++; $display("FAIL error_bin bcd=%h got %h want %h", vals[k], b, ex[15:0]); end
      n_cmp++; if (e !== ex[32])   begin n_fail++; $display("FAIL error_err bcd=%h got %b want %b", vals[k], e, ex[32]); end
    end
  endtask

  task automatic test_backpressure();
    int lat; int seen; logic [32:0] ex;
    accept4(16'h9999, 1'b1);
    wait_done4(lat);
    ex = sb_q.pop_front();
    n_cmp++; if (lat !== 16) begin n_fail++; $display("FAIL bp_latency got %0d want 16", lat); end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        in_valid = 1'b1;
        bcd_in   = 16'h1111;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_valid cyc=%0d got %b want 1", c, out_valid); end
      n_cmp++; if (bin_out !== ex[15:0]) begin n_fail++; $display("FAIL bp_bin cyc=%0d got %h want %h", c, bin_out, ex[15:0]); end
      n_cmp++; if (err !== ex[32])      begin n_fail++; $display("FAIL bp_err cyc=%0d got %b want %b", c, err, ex[32]); end
      n_cmp++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_ready cyc=%0d got %b want 0", c, in_ready); end
    end
    $display("txn dut4 bcd=9999 held bin=%h err=%b", bin_out, err);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL bp_ignored_input got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_shift();
    int seen; int lat; logic [15:0] b; logic e, r, v; logic [32:0] ex;
    accept4(16'h4321, 1'b0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    n_cmp++; if (bin_out !== 16'h0)  begin n_fail++; $display("FAIL rst_mid_bin got %h want 0000", bin_out); end
    n_cmp++; if (err !== 1'b0)       begin n_fail++; $display("FAIL rst_mid_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_result got %0d valid cycles want 0", seen); end
    run4(16'h0500, lat, b, e, r, v);
    ex = sb_q.pop_front();
    n_cmp++; if (lat !== 16)     begin n_fail++; $display("FAIL rst_after_latency got %0d want 16", lat); end
    n_cmp++; if (b !== ex[15:0]) begin n_fail++; $display("FAIL rst_after_bin got %h want %h", b, ex[15:0]); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] b; logic e, r, v; logic [32:0] ex;
    time prev_t;
    for (int k = 0; k < 6; k++) begin
      logic [15:0] val;
      for (int d = 0; d < 4; d++) val[4*d +: 4] = 4'($urandom_range(0, 9));
      if (k == 3) val[7:4] = 4'hF;
      prev_t = accept_t;
      run4(val, lat, b, e, r, v);
      ex = sb_q.pop_front();
      n_cmp++; if (b !== ex[15:0]) begin n_fail++; $display("FAIL b2b_bin bcd=%h got %h want %h", val, b, ex[15:0]); end
      n_cmp++; if (e !== ex[32])   begin n_fail++; $display("FAIL b2b_err bcd=%h got %b want %b", val, e, ex[32]); end
      if (k > 0) begin
        n_cmp++;
        if (accept_t - prev_t !== 180) begin
          n_fail++;
          $display("FAIL b2b_period got %0t want 180", accept_t - prev_t);
        end
      end
    end
  endtask

  task automatic test_digits2();
    logic [7:0] vals[3] = '{8'h99, 8'h9F, 8'h47};
    int lat; logic [7:0] b; logic e; logic [32:0] ex;
    foreach (vals[k]) begin
      run2(vals[k], lat, b, e);
      ex = sb_q.pop_front();
      n_cmp++; if (lat !== 8)     begin n_fail++; $display("FAIL d2_latency bcd=%h got %0d want 8", vals[k], lat); end
      n_cmp++; if (b !== ex[7:0]) begin n_fail++; $display("FAIL d2_bin bcd=%h got %h want %h", vals[k], b, ex[7:0]); end
      n_cmp++; if (e !== ex[32])  begin n_fail++; $display("FAIL d2_err bcd=%h got %b want %b", vals[k], e, ex[32]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_error();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_digits2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
